// File: rtl/lexer_pkg.sv
// Shared lexer definitions: token kind encodings, token record and the
// indentation scheduler's state encoding.
package lexer_pkg;

  localparam int TOK_KIND_W = 4;
  localparam int TOK_TEXT_W = 32;

  localparam logic [TOK_KIND_W-1:0] KIND_NAME    = 4'd1;
  localparam logic [TOK_KIND_W-1:0] KIND_INT     = 4'd2;
  localparam logic [TOK_KIND_W-1:0] KIND_FLOAT   = 4'd3;
  localparam logic [TOK_KIND_W-1:0] KIND_OP      = 4'd4;
  localparam logic [TOK_KIND_W-1:0] KIND_NEWLINE = 4'd5;
  localparam logic [TOK_KIND_W-1:0] KIND_INDENT  = 4'd6;
  localparam logic [TOK_KIND_W-1:0] KIND_DEDENT  = 4'd7;
  localparam logic [TOK_KIND_W-1:0] KIND_EOF     = 4'd8;

  typedef struct packed {
    logic [TOK_KIND_W-1:0] kind;
    logic [TOK_TEXT_W-1:0] text;
  } token_t;

  typedef enum logic [2:0] {PASS, UP, DOWN, HELD, DONE, ERR} sched_state_e;

endpackage

// File: rtl/token_out_reg.sv
// Single-entry valid/ready output register: loads on strobe, holds its
// payload stable while stalled, and reports when a new load may be issued.
module token_out_reg #(
  parameter int KIND_W = 4,
  parameter int TEXT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [KIND_W-1:0] i_kind,
  input  logic [TEXT_W-1:0] i_text,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [KIND_W-1:0] o_kind,
  output logic [TEXT_W-1:0] o_text,
  output logic              o_free
);

  logic              r_valid;
  logic [KIND_W-1:0] r_kind;
  logic [TEXT_W-1:0] r_text;

  // The slot is free when empty or when its current token leaves this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_kind  = r_kind;
  assign o_text  = r_text;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_kind  <= '0;
      r_text  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_kind  <= i_kind;
      r_text  <= i_text;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/token_indent_scheduler.sv
// Inserts INDENT/DEDENT tokens ahead of the first token of each line,
// flushes open levels before EOF and halts on malformed indentation.
module token_indent_scheduler
  import lexer_pkg::*;
#(
  parameter int KIND_W      = 4,
  parameter int TEXT_W      = 32,
  parameter int COL_W       = 8,
  parameter int INDENT_UNIT = 4,
  parameter int MAX_LEVEL   = 15,
  parameter int LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [KIND_W-1:0]  s_kind,
  input  logic [TEXT_W-1:0]  s_text,
  input  logic               s_bol,
  input  logic [COL_W-1:0]   s_indent,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [KIND_W-1:0]  m_kind,
  output logic [TEXT_W-1:0]  m_text,
  output logic [LEVEL_W-1:0] level,
  output logic               err_align,
  output logic               err_depth
);

  localparam int SHIFT = $clog2(INDENT_UNIT);

  sched_state_e       r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] r_tgt;
  logic [KIND_W-1:0]  r_holdKind;
  logic [TEXT_W-1:0]  r_holdText;
  logic               r_errAlign;
  logic               r_errDepth;

  logic [COL_W-1:0]   w_tgtWide;
  logic [LEVEL_W-1:0] w_tgt;
  logic [LEVEL_W-1:0] w_levelUp;
  logic [LEVEL_W-1:0] w_levelDown;
  logic               w_misaligned;
  logic               w_tooDeep;
  logic               w_isEof;
  logic               w_accept;
  logic               w_free;
  logic               w_load;
  logic [KIND_W-1:0]  w_loadKind;
  logic [TEXT_W-1:0]  w_loadText;

  assign w_tgtWide    = s_indent >> SHIFT;
  assign w_tgt        = w_tgtWide[LEVEL_W-1:0];
  assign w_misaligned = (s_indent & COL_W'(INDENT_UNIT - 1)) != '0;
  assign w_tooDeep    = w_tgtWide > COL_W'(MAX_LEVEL);
  assign w_isEof      = s_kind == KIND_W'(KIND_EOF);
  assign w_levelUp    = r_level + LEVEL_W'(1);
  assign w_levelDown  = r_level - LEVEL_W'(1);

  assign s_ready   = !rst && (r_state == PASS) && w_free;
  assign w_accept  = s_valid && s_ready;
  assign level     = r_level;
  assign err_align = r_errAlign;
  assign err_depth = r_errDepth;

  // Chooses what, if anything, enters the output slot this cycle.
  always_comb begin
    w_load     = 1'b0;
    w_loadKind = s_kind;
    w_loadText = s_text;
    case (r_state)
      PASS: begin
        if (w_accept) begin
          if (w_isEof)    w_load = (r_level == '0);
          else if (s_bol) w_load = !w_misaligned && !w_tooDeep && (w_tgt == r_level);
          else            w_load = 1'b1;
        end
      end
      UP: begin
        w_load     = w_free;
        w_loadKind = KIND_W'(KIND_INDENT);
        w_loadText = '0;
      end
      DOWN: begin
        w_load     = w_free;
        w_loadKind = KIND_W'(KIND_DEDENT);
        w_loadText = '0;
      end
      HELD: begin
        w_load     = w_free;
        w_loadKind = r_holdKind;
        w_loadText = r_holdText;
      end
      default: ;
    endcase
  end

  // Level transitions finish on the same load that reaches the target, so
  // multi-level bursts run back to back without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PASS;
      r_level    <= '0;
      r_tgt      <= '0;
      r_holdKind <= '0;
      r_holdText <= '0;
      r_errAlign <= 1'b0;
      r_errDepth <= 1'b0;
    end else begin
      case (r_state)
        PASS: begin
          if (w_accept) begin
            if (w_isEof) begin
              if (r_level == '0) begin
                r_state <= DONE;
              end else begin
                r_holdKind <= s_kind;
                r_holdText <= s_text;
                r_tgt      <= '0;
                r_state    <= DOWN;
              end
            end else if (s_bol) begin
              if (w_misaligned || w_tooDeep) begin
                r_errAlign <= r_errAlign | w_misaligned;
                r_errDepth <= r_errDepth | w_tooDeep;
                r_state    <= ERR;
              end else if (w_tgt != r_level) begin
                r_holdKind <= s_kind;
                r_holdText <= s_text;
                r_tgt      <= w_tgt;
                r_state    <= (w_tgt > r_level) ? UP : DOWN;
              end
            end
          end
        end
        UP: begin
          if (w_free) begin
            r_level <= w_levelUp;
            if (w_levelUp == r_tgt) r_state <= HELD;
          end
        end
        DOWN: begin
          if (w_free) begin
            r_level <= w_levelDown;
            if (w_levelDown == r_tgt) r_state <= HELD;
          end
        end
        HELD: begin
          if (w_free) r_state <= (r_holdKind == KIND_W'(KIND_EOF)) ? DONE : PASS;
        end
        default: ;
      endcase
    end
  end

  token_out_reg #(
    .KIND_W (KIND_W),
    .TEXT_W (TEXT_W)
  ) u_outReg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_kind  (w_loadKind),
    .i_text  (w_loadText),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_kind  (m_kind),
    .o_text  (m_text),
    .o_free  (w_free)
  );

endmodule

// File: tb/tb_token_indent_scheduler.sv
// Directed bench for token_indent_scheduler: flat stream, nesting, EOF flush,
// backpressure, indentation errors and reset during a DEDENT burst.
module tb_token_indent_scheduler;
  import lexer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_kind = '0;
  logic [31:0] s_text = '0;
  logic        s_bol = 1'b0;
  logic [7:0]  s_indent = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [3:0]  m_kind;
  logic [31:0] m_text;
  logic [3:0]  level;
  logic        err_align;
  logic        err_depth;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  token_indent_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_kind    (s_kind),
    .s_text    (s_text),
    .s_bol     (s_bol),
    .s_indent  (s_indent),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_kind    (m_kind),
    .m_text    (m_text),
    .level     (level),
    .err_align (err_align),
    .err_depth (err_depth)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] k, input logic [31:0] t,
                               input logic b, input logic [7:0] ind);
    s_valid  = v;
    s_kind   = k;
    s_text   = t;
    s_bol    = b;
    s_indent = ind;
    #1;
  endtask

  // Offer one token, require it to be accepted on the next edge.
  task automatic send(input string tag, input logic [3:0] k, input logic [31:0] t,
                      input logic b, input logic [7:0] ind);
    applyStimulus(1'b1, k, t, b, ind);
    checkOutput({tag, "/s_ready"}, 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    #1;
  endtask

  task automatic expectTok(input string tag, input logic [3:0] k, input logic [31:0] t,
                           input logic [3:0] lvl);
    checkOutput({tag, "/m_valid"}, 32'(m_valid), 32'd1);
    checkOutput({tag, "/m_kind"}, 32'(m_kind), 32'(k));
    checkOutput({tag, "/m_text"}, m_text, t);
    checkOutput({tag, "/level"}, 32'(level), 32'(lvl));
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    m_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 8'd0);
    tick();
    tick();
    checkOutput({tag, "/rst s_ready"}, 32'(s_ready), 32'd0);
    checkOutput({tag, "/rst m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "/rst m_kind"}, 32'(m_kind), 32'd0);
    checkOutput({tag, "/rst m_text"}, m_text, 32'd0);
    checkOutput({tag, "/rst level"}, 32'(level), 32'd0);
    checkOutput({tag, "/rst err_align"}, 32'(err_align), 32'd0);
    checkOutput({tag, "/rst err_depth"}, 32'(err_depth), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput({tag, "/post-rst s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    // Flat stream: one token per cycle, 1-cycle latency, level stays 0.
    doReset("flat");
    send("flat0", KIND_NAME, 32'hA1, 1'b1, 8'd0);
    expectTok("flat0", KIND_NAME, 32'hA1, 4'd0);
    send("flat1", KIND_OP, 32'hA2, 1'b0, 8'd0);
    expectTok("flat1", KIND_OP, 32'hA2, 4'd0);
    send("flat2", KIND_INT, 32'hA3, 1'b0, 8'd0);
    expectTok("flat2", KIND_INT, 32'hA3, 4'd0);
    send("flat3", KIND_NEWLINE, 32'hA4, 1'b0, 8'd0);
    expectTok("flat3", KIND_NEWLINE, 32'hA4, 4'd0);
    send("flat4", KIND_EOF, 32'h0, 1'b0, 8'd0);
    expectTok("flat4", KIND_EOF, 32'h0, 4'd0);
    checkOutput("flat/done s_ready", 32'(s_ready), 32'd0);
    tick();
    checkOutput("flat/done m_valid", 32'(m_valid), 32'd0);

    // Nested block: indents 0 -> 4 -> 12 -> 0, then EOF.
    doReset("nest");
    send("nest1", KIND_NAME, 32'h11, 1'b1, 8'd0);
    expectTok("nest1", KIND_NAME, 32'h11, 4'd0);
    send("nest1nl", KIND_NEWLINE, 32'h0, 1'b0, 8'd0);
    expectTok("nest1nl", KIND_NEWLINE, 32'h0, 4'd0);
    send("nest2", KIND_NAME, 32'h22, 1'b1, 8'd4);
    checkOutput("nest2/gap m_valid", 32'(m_valid), 32'd0);
    checkOutput("nest2/up s_ready", 32'(s_ready), 32'd0);
    tick();
    expectTok("nest2/ind", KIND_INDENT, 32'h0, 4'd1);
    tick();
    expectTok("nest2/tok", KIND_NAME, 32'h22, 4'd1);
    send("nest2nl", KIND_NEWLINE, 32'h0, 1'b0, 8'd0);
    expectTok("nest2nl", KIND_NEWLINE, 32'h0, 4'd1);
    send("nest3", KIND_NAME, 32'h33, 1'b1, 8'd12);
    checkOutput("nest3/gap m_valid", 32'(m_valid), 32'd0);
    tick();
    expectTok("nest3/ind1", KIND_INDENT, 32'h0, 4'd2);
    tick();
    expectTok("nest3/ind2", KIND_INDENT, 32'h0, 4'd3);
    tick();
    expectTok("nest3/tok", KIND_NAME, 32'h33, 4'd3);
    send("nest3nl", KIND_NEWLINE, 32'h0, 1'b0, 8'd0);
    expectTok("nest3nl", KIND_NEWLINE, 32'h0, 4'd3);
    send("nest4", KIND_NAME, 32'h44, 1'b1, 8'd0);
    checkOutput("nest4/gap m_valid", 32'(m_valid), 32'd0);
    tick();
    expectTok("nest4/ded1", KIND_DEDENT, 32'h0, 4'd2);
    tick();
    expectTok("nest4/ded2", KIND_DEDENT, 32'h0, 4'd1);
    tick();
    expectTok("nest4/ded3", KIND_DEDENT, 32'h0, 4'd0);
    tick();
    expectTok("nest4/tok", KIND_NAME, 32'h44, 4'd0);
    send("nestEof", KIND_EOF, 32'h0, 1'b0, 8'd0);
    expectTok("nestEof", KIND_EOF, 32'h0, 4'd0);

    // EOF while at level 2 flushes two DEDENTs before the EOF.
    doReset("eof");
    send("eof1", KIND_NAME, 32'h51, 1'b1, 8'd0);
    expectTok("eof1", KIND_NAME, 32'h51, 4'd0);
    send("eof2", KIND_NAME, 32'h55, 1'b1, 8'd8);
    tick();
    expectTok("eof2/ind1", KIND_INDENT, 32'h0, 4'd1);
    tick();
    expectTok("eof2/ind2", KIND_INDENT, 32'h0, 4'd2);
    tick();
    expectTok("eof2/tok", KIND_NAME, 32'h55, 4'd2);
    send("eofTok", KIND_EOF, 32'h0, 1'b0, 8'd0);
    checkOutput("eof/gap m_valid", 32'(m_valid), 32'd0);
    tick();
    expectTok("eof/ded1", KIND_DEDENT, 32'h0, 4'd1);
    tick();
    expectTok("eof/ded2", KIND_DEDENT, 32'h0, 4'd0);
    tick();
    expectTok("eof/eof", KIND_EOF, 32'h0, 4'd0);
    applyStimulus(1'b1, KIND_NAME, 32'h5F, 1'b0, 8'd0);
    checkOutput("eof/done s_ready", 32'(s_ready), 32'd0);
    tick();
    checkOutput("eof/done m_valid", 32'(m_valid), 32'd0);
    checkOutput("eof/done s_ready2", 32'(s_ready), 32'd0);
    tick();
    checkOutput("eof/done s_ready3", 32'(s_ready), 32'd0);

    // Backpressure during an INDENT burst: nothing advances until handshake.
    doReset("bp");
    send("bp1", KIND_NAME, 32'h61, 1'b1, 8'd0);
    expectTok("bp1", KIND_NAME, 32'h61, 4'd0);
    send("bp2", KIND_NAME, 32'h66, 1'b1, 8'd8);
    m_ready = 1'b0;
    tick();
    expectTok("bp/ind1", KIND_INDENT, 32'h0, 4'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expectTok("bp/stall", KIND_INDENT, 32'h0, 4'd1);
    end
    m_ready = 1'b1;
    tick();
    expectTok("bp/ind2", KIND_INDENT, 32'h0, 4'd2);
    tick();
    expectTok("bp/tok", KIND_NAME, 32'h66, 4'd2);
    tick();
    checkOutput("bp/empty m_valid", 32'(m_valid), 32'd0);

    // Misaligned indent raises err_align and stops the stream.
    doReset("align");
    send("align1", KIND_NAME, 32'h71, 1'b1, 8'd0);
    expectTok("align1", KIND_NAME, 32'h71, 4'd0);
    send("align2", KIND_NAME, 32'h77, 1'b1, 8'd6);
    checkOutput("align/err_align", 32'(err_align), 32'd1);
    checkOutput("align/err_depth", 32'(err_depth), 32'd0);
    checkOutput("align/m_valid", 32'(m_valid), 32'd0);
    checkOutput("align/level", 32'(level), 32'd0);
    applyStimulus(1'b1, KIND_NAME, 32'h78, 1'b0, 8'd0);
    checkOutput("align/s_ready", 32'(s_ready), 32'd0);
    tick();
    checkOutput("align/s_ready2", 32'(s_ready), 32'd0);
    checkOutput("align/m_valid2", 32'(m_valid), 32'd0);
    checkOutput("align/sticky", 32'(err_align), 32'd1);

    // Too deep: indent 64 gives target 16.
    doReset("depth");
    send("depth1", KIND_NAME, 32'h81, 1'b1, 8'd64);
    checkOutput("depth/err_depth", 32'(err_depth), 32'd1);
    checkOutput("depth/err_align", 32'(err_align), 32'd0);
    checkOutput("depth/m_valid", 32'(m_valid), 32'd0);
    checkOutput("depth/s_ready", 32'(s_ready), 32'd0);

    // Both faults at once: indent 66.
    doReset("both");
    send("both1", KIND_NAME, 32'h82, 1'b1, 8'd66);
    checkOutput("both/err_depth", 32'(err_depth), 32'd1);
    checkOutput("both/err_align", 32'(err_align), 32'd1);

    // Reset in the middle of a DEDENT burst drops the pending DEDENTs.
    doReset("rdown");
    send("rdown1", KIND_NAME, 32'h91, 1'b1, 8'd12);
    tick();
    tick();
    tick();
    tick();
    expectTok("rdown1/tok", KIND_NAME, 32'h91, 4'd3);
    send("rdown2", KIND_NAME, 32'h88, 1'b1, 8'd0);
    tick();
    expectTok("rdown/ded1", KIND_DEDENT, 32'h0, 4'd2);
    doReset("rdownRst");
    send("rdown3", KIND_NAME, 32'h99, 1'b1, 8'd0);
    expectTok("rdown3", KIND_NAME, 32'h99, 4'd0);
    tick();
    checkOutput("rdown/empty m_valid", 32'(m_valid), 32'd0);
    checkOutput("rdown/level", 32'(level), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/token_indent_scheduler.md
Name: token_indent_scheduler

Overview:
Sits between the character scanner and the parser's token FIFO in the hardware lexer. It tracks the current indentation level and inserts INDENT/DEDENT tokens in front of the first token of each line. It merges these synthetic tokens with the scanner's own tokens onto a single valid/ready output stream, and flushes outstanding DEDENTs before EOF. It also detects malformed indentation and stops the stream when it finds it.

Parameters:
KIND_W, 4, width of the token-kind field (encodings come from the shared package)
TEXT_W, 32, width of the token payload (lexeme hash or literal bits), passed through unchanged
COL_W, 8, width of the leading-space count for each line
INDENT_UNIT, 4, number of spaces per indentation level (power of two)
MAX_LEVEL, 15, deepest legal indentation level
LEVEL_W, 4, width of the level counter; must satisfy 2**LEVEL_W > MAX_LEVEL

Ports:
clk  in  1  single clock; every register updates on its rising edge
rst  in  1  reset, synchronous and active-high
s_valid  in  1  scanner token valid
s_ready  out  1  scheduler accepts the scanner token this cycle
s_kind  in  KIND_W  scanner token kind
s_text  in  TEXT_W  scanner token payload
s_bol  in  1  token is the first token on a non-blank line
s_indent  in  COL_W  leading-space count of that line; only meaningful when s_bol=1
m_valid  out  1  output token valid
m_ready  in  1  downstream accepts the output token
m_kind  out  KIND_W  output token kind
m_text  out  TEXT_W  output token payload; all zeros for INDENT and DEDENT
level  out  LEVEL_W  current indentation level
err_align  out  1  sticky: s_indent was not a multiple of INDENT_UNIT
err_depth  out  1  sticky: target level was greater than MAX_LEVEL

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_kind=0, m_text=0, level=0, err_align=0, err_depth=0, state=PASS, hold register cleared. s_ready rises in the first cycle after rst deasserts.
- Reset mid-operation: anything held or partly emitted is dropped, with no partial INDENT/DEDENT bursts after reset.
- Output register: m_* are registered; an m_* transfer completes when m_valid && m_ready.
- Stability rule: m_kind and m_text hold stable while m_valid && !m_ready.
- Target level: tgt = s_indent / INDENT_UNIT, computed with a shift.
- Alignment check: the low log2(INDENT_UNIT) bits of s_indent must be zero.
- State PASS:
  - s_ready = !m_valid || m_ready.
  - Accepting a token with s_bol=0 loads it straight into the output register. Latency is 1 cycle.
  - Accepting a token with s_bol=1 and tgt==level behaves the same as s_bol=0.
  - Accepting a token with s_bol=1 and tgt>level: capture the token in the hold register, latch tgt, go to UP.
  - Accepting a token with s_bol=1 and tgt<level: capture the token in the hold register, latch tgt, go to DOWN.
  - Accepting KIND_EOF with level>0 (s_bol is ignored): hold the EOF, set tgt=0, go to DOWN.
  - Accepting KIND_EOF with level==0: the EOF is passed through, then go to DONE.
- State UP: load one INDENT per free output slot; level increments on each load. When level==tgt, go to HELD.
- State DOWN: load one DEDENT per free output slot; level decrements on each load. When level==tgt, go to HELD.
- State HELD: load the held token into the output register when the slot is free. Next state is PASS, or DONE if the held token was EOF.
- s_ready=0 in UP, DOWN, HELD, DONE and ERR.
- State DONE: no more input is accepted; m_valid drops once the EOF handshake completes. Only rst leaves DONE.
- Errors: checked at acceptance of an s_bol=1 token.
  - Misaligned s_indent sets err_align.
  - tgt>MAX_LEVEL sets err_depth.
  - If both conditions hold, both flags set in the same cycle.
  - The token is consumed but not forwarded, level is unchanged, and the state goes to ERR.
  - In ERR: s_ready=0; a token already in the output register still drains; after that m_valid=0. Only rst clears ERR.
- Multi-level jumps (for example 0 to 3) produce consecutive INDENTs with no bubble while m_ready=1.
- Throughput is 1 token per cycle in PASS with m_ready held high.
- Blank or comment-only lines are removed upstream; s_bol is never asserted for them.

Decomposition:
- Package lexer_pkg holds:
  - the kind encodings KIND_NAME, KIND_INT, KIND_FLOAT, KIND_OP, KIND_NEWLINE, KIND_INDENT, KIND_DEDENT, KIND_EOF;
  - a packed struct token_t {kind, text};
  - the state enum {PASS, UP, DOWN, HELD, DONE, ERR}.
- One sub-module, token_out_reg: the valid/ready output register with a load strobe and the stall-hold rule. The FSM and level counter stay in the top module.

Test Plan:
- Flat stream: NAME(s_bol=1, s_indent=0), OP, INT, NEWLINE, EOF with m_ready=1 -> the same 5 tokens out, one per cycle, level=0 throughout, 1-cycle latency.
- Nested block: line 2 s_indent=4, line 3 s_indent=12, line 4 s_indent=0, then EOF -> INDENT before line 2; INDENT,INDENT before line 3; DEDENT,DEDENT,DEDENT before line 4; level sequence 1, 3, 0.
- EOF flush: stream ends while level=2 -> DEDENT, DEDENT, EOF; state DONE; s_ready stays 0 afterwards.
- Backpressure: m_ready held 0 for 5 cycles during an INDENT burst -> m_kind stays KIND_INDENT; no token lost or duplicated; level advances only on handshake.
- Misaligned indent: s_bol=1, s_indent=6 -> err_align=1 next cycle; token not forwarded; s_ready=0 until rst. With s_indent=64 (tgt=16) -> err_depth=1.
- Reset during DOWN with 2 DEDENTs pending -> after rst: m_valid=0, level=0, both error flags 0, and PASS accepts new input.
